// File: rtl/fibgyro_pkg.sv
// rtl/fibgyro_pkg.sv - shared types and constants for the fiber-gyro frame parser
// Purpose: parser state encoding and frame-format constants.
package fibgyro_pkg;

  typedef enum logic [1:0] {
    HUNT_H0 = 2'd0,
    HUNT_H1 = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } fibgy_state_t;

  localparam logic [7:0] FIBGY_HDR0        = 8'hEB;
  localparam logic [7:0] FIBGY_HDR1        = 8'h90;
  localparam int         FIBGY_PAYLOAD_LEN = 6;
  localparam int         FIBGY_FRAME_LEN   = 9;

endpackage

// File: rtl/fibgyro_gap_timer.sv
// rtl/fibgyro_gap_timer.sv - saturating inter-byte gap timer
// Purpose: counts idle cycles between received bytes while a frame is in progress.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : restart the count (a byte was received)
//   i_enable       : count only while enabled, otherwise held at 0
//   o_expired      : high while enabled and the count sits at TIMEOUT_CYC
module fibgyro_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 156250
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);

  logic [TW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The consumer leaves the enabled state on expiry, which clears the count,
  // so this is high for a single cycle per timeout.
  assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/fibgyro_frame_parser.sv
// rtl/fibgyro_frame_parser.sv - gyro telemetry frame parser with checksum and status counters
// Purpose: hunts for the EB 90 header, collects three big-endian 16-bit rates,
// verifies the 8-bit additive checksum and publishes validated rates.
// Ports:
//   CLK, RESET                       : clock, synchronous active-high reset
//   rx_valid, rx_byte                : received byte strobe and data
//   rate_x, rate_y, rate_z           : last validated rates
//   frame_valid                      : one-cycle pulse when rates update
//   frame_cnt, csum_err_cnt, timeout_cnt : wrapping status counters
//   busy                             : parser is inside a frame
module fibgyro_frame_parser
  import fibgyro_pkg::*;
#(
  parameter logic [7:0]  HDR0        = FIBGY_HDR0,
  parameter logic [7:0]  HDR1        = FIBGY_HDR1,
  parameter int unsigned TIMEOUT_CYC = 156250,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  output logic [15:0]      rate_x,
  output logic [15:0]      rate_y,
  output logic [15:0]      rate_z,
  output logic             frame_valid,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] csum_err_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             busy
);

  localparam logic [2:0] LAST_IDX = 3'(FIBGY_PAYLOAD_LEN - 1);

  fibgy_state_t                          r_state;
  logic [2:0]                            r_idx;
  logic [7:0]                            r_acc;
  logic [FIBGY_PAYLOAD_LEN-1:0][7:0]     r_shadow;
  logic                                  w_expired;

  fibgyro_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .i_clk     (CLK),
    .i_reset   (RESET),
    .i_clear   (rx_valid),
    .i_enable  (r_state != HUNT_H0),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= HUNT_H0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_shadow     <= '0;
      rate_x       <= '0;
      rate_y       <= '0;
      rate_z       <= '0;
      frame_valid  <= 1'b0;
      frame_cnt    <= '0;
      csum_err_cnt <= '0;
      timeout_cnt  <= '0;
    end else begin
      frame_valid <= 1'b0;
      // An expired gap abandons the frame; a byte arriving on that same
      // cycle is dropped along with it.
      if (w_expired) begin
        r_state     <= HUNT_H0;
        timeout_cnt <= timeout_cnt + 1'b1;
      end else if (rx_valid) begin
        case (r_state)
          HUNT_H0: begin
            if (rx_byte == HDR0) r_state <= HUNT_H1;
          end
          HUNT_H1: begin
            if (rx_byte == HDR1) begin
              r_state <= PAYLOAD;
              r_idx   <= '0;
              r_acc   <= '0;
            end else if (rx_byte != HDR0) begin
              r_state <= HUNT_H0;
            end
          end
          PAYLOAD: begin
            // Shadow slot 0 is the X high byte; header values here are data.
            r_shadow[r_idx] <= rx_byte;
            r_acc           <= r_acc + rx_byte;
            r_idx           <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) r_state <= CHECK;
          end
          CHECK: begin
            if (rx_byte == r_acc) begin
              rate_x      <= {r_shadow[0], r_shadow[1]};
              rate_y      <= {r_shadow[2], r_shadow[3]};
              rate_z      <= {r_shadow[4], r_shadow[5]};
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 1'b1;
            end else begin
              csum_err_cnt <= csum_err_cnt + 1'b1;
            end
            r_state <= HUNT_H0;
          end
          default: r_state <= HUNT_H0;
        endcase
      end
    end
  end

  assign busy = (r_state != HUNT_H0);

endmodule

// File: doc/fibgyro_frame_parser.md
Name: fibgyro_frame_parser

Overview:
- Downstream consumer of the fiber-gyro UART control stage.
- Takes the one-cycle received-byte strobe and byte from that stage and hunts for the gyro telemetry frame header.
- Assembles three 16-bit angular-rate words and verifies the frame checksum.
- Publishes validated rates with a one-cycle frame strobe, plus error and timeout counters for housekeeping telemetry.

Parameters:
HDR0, 8'hEB, first header byte
HDR1, 8'h90, second header byte
TIMEOUT_CYC, 156250, max CLK cycles between bytes inside a frame (~3 byte times at 9600 baud, 50 MHz)
CNT_W, 16, width of status counters

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_byte holds a new received byte
rx_byte  in  8  received byte from the UART control stage
rate_x  out  16  last validated X rate, big-endian assembled, two's complement
rate_y  out  16  last validated Y rate
rate_z  out  16  last validated Z rate
frame_valid  out  1  one-cycle pulse when rate_* update
frame_cnt  out  CNT_W  good frames received, wraps
csum_err_cnt  out  CNT_W  checksum failures, wraps
timeout_cnt  out  CNT_W  inter-byte timeouts, wraps
busy  out  1  high in any state other than HUNT_H0

Behaviour:
- Interface (already decided): one clock, CLK. RESET is synchronous and active-high.
- Reset values: all outputs 0, state HUNT_H0, gap timer 0, byte index 0, checksum accumulator 0.
- Frame format: HDR0, HDR1, X_hi, X_lo, Y_hi, Y_lo, Z_hi, Z_lo, CSUM. 9 bytes total.
- CSUM is the low 8 bits of the sum of the 6 payload bytes. Header bytes are excluded.
- States advance only on cycles with rx_valid=1. Bytes without rx_valid are ignored.
- HUNT_H0: byte==HDR0 -> HUNT_H1; else stay.
- HUNT_H1:
  - byte==HDR1 -> PAYLOAD, index=0, accumulator=0.
  - byte==HDR0 -> stay in HUNT_H1 (resync on repeated header byte).
  - else -> HUNT_H0.
- PAYLOAD:
  - Store byte into shadow register slot index. Add it to the accumulator (mod 256). index++.
  - After index 5 is stored -> CHECK.
  - Header values inside the payload are treated as data; no resync.
- CHECK:
  - byte==accumulator: copy shadow into rate_x/y/z, pulse frame_valid, frame_cnt++.
  - else: csum_err_cnt++ and rate_* unchanged.
  - Either way -> HUNT_H0.
- Latency: rate_* and frame_valid change on the CLK edge after the cycle in which the CSUM byte's rx_valid is sampled. frame_valid is high for exactly 1 cycle.
- Gap timer:
  - Cleared on every rx_valid. Also held at 0 while in HUNT_H0.
  - Otherwise increments, saturating at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC in any non-HUNT_H0 state forces HUNT_H0 and increments timeout_cnt once.
- Simultaneous rx_valid and timer==TIMEOUT_CYC-1: the byte is processed and the timer cleared. No timeout occurs.
- Counters wrap from all-ones to 0 with no saturation.
- RESET mid-frame discards the partial frame. rate_* return to 0.
- Shadow registers are never visible on rate_*. Outputs change only on a good frame or RESET.

Decomposition:
- Package fibgyro_pkg holds:
  - state enum: HUNT_H0, HUNT_H1, PAYLOAD, CHECK.
  - constants: FIBGY_HDR0, FIBGY_HDR1, FIBGY_PAYLOAD_LEN=6, FIBGY_FRAME_LEN=9.
- One sub-module, fibgyro_gap_timer: saturating gap counter with clear, enable, and a one-cycle expired output, parameter TIMEOUT_CYC.
- The parser FSM and datapath stay in the top.

Test Plan:
- Good frame: EB 90 01 02 FF FE 80 00 80, bytes 10 cycles apart -> rate_x=0x0102, rate_y=0xFFFE, rate_z=0x8000, frame_valid one pulse 1 cycle after the CSUM strobe, frame_cnt=1.
- Bad checksum: same frame with CSUM 81 -> no frame_valid, rate_* unchanged from the prior frame, csum_err_cnt=1.
- Resync: stream EB EB 90 + valid payload/CSUM -> accepted, frame_cnt increments. Stream 55 EB 11 EB 90 ... -> only the second header is accepted.
- Timeout: EB 90 01 02, then silence for TIMEOUT_CYC cycles -> timeout_cnt=1, busy falls. Following full good frame accepted normally.
- Boundary: next byte's rx_valid arrives at timer==TIMEOUT_CYC-1 -> no timeout, frame completes. RESET asserted after the 4th payload byte -> all outputs 0. Next good frame accepted.
- Wrap: preload frame_cnt to 0xFFFF (force or 65535 frames) plus one good frame -> frame_cnt=0x0000.
